// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: button conditioning, move legality,
// turn alternation and win/draw detection. Owns the board registers.
module ttt_game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_W           = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [8:0]  btn_n,
    input  logic        new_game_n,
    output logic [17:0] board,
    output logic        player,
    output logic [1:0]  game_state,
    output logic [7:0]  win_line,
    output logic [3:0]  move_count,
    output logic        move_valid
);

    localparam logic [1:0] PLAY  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] OVER  = 2'd2;

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]       sync1;
    logic [9:0]       sync2;
    logic [9:0]       lvl;
    logic [9:0]       lvl_q;
    logic [9:0]       press;
    logic [9:0]       samp;
    logic [CNT_W-1:0] cnt [10];
    logic [1:0]       state;

    assign samp  = ~sync2;
    assign press = lvl & ~lvl_q;

    // lvl is the debounced "pressed" level; bit 9 is new-game
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '1;
            sync2 <= '1;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 10; i++) cnt[i] <= '0;
        end else begin
            sync1 <= {new_game_n, btn_n};
            sync2 <= sync1;
            lvl_q <= lvl;
            for (int i = 0; i < 10; i++) begin
                if (samp[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_MAX) begin
                    lvl[i] <= samp[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic       cell_hit;
    logic [3:0] cell_idx;
    logic       cell_free;
    logic       ng_evt;

    assign ng_evt = press[9];

    // Downward scan so the lowest pressed index wins
    always_comb begin
        cell_hit = 1'b0;
        cell_idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (press[i]) begin
                cell_hit = 1'b1;
                cell_idx = 4'(i);
            end
        end
    end

    assign cell_free = (board[{cell_idx, 1'b0} +: 2] == 2'b00);

    logic [1:0] code;
    logic [7:0] win_hits;

    assign code = {player, ~player};

    function automatic logic line3(input logic [17:0] b, input int a,
                                   input int m, input int c,
                                   input logic [1:0] k);
        return (b[2*a +: 2] == k) && (b[2*m +: 2] == k) &&
               (b[2*c +: 2] == k);
    endfunction

    always_comb begin
        win_hits    = '0;
        win_hits[0] = line3(board, 0, 1, 2, code);
        win_hits[1] = line3(board, 3, 4, 5, code);
        win_hits[2] = line3(board, 6, 7, 8, code);
        win_hits[3] = line3(board, 0, 3, 6, code);
        win_hits[4] = line3(board, 1, 4, 7, code);
        win_hits[5] = line3(board, 2, 5, 8, code);
        win_hits[6] = line3(board, 0, 4, 8, code);
        win_hits[7] = line3(board, 2, 4, 6, code);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            board      <= '0;
            player     <= 1'b0;
            game_state <= 2'b00;
            win_line   <= '0;
            move_count <= '0;
            move_valid <= 1'b0;
            state      <= PLAY;
        end else begin
            move_valid <= 1'b0;
            if (ng_evt) begin
                board      <= '0;
                player     <= 1'b0;
                game_state <= 2'b00;
                win_line   <= '0;
                move_count <= '0;
                state      <= PLAY;
            end else begin
                unique case (state)
                    PLAY: begin
                        if (cell_hit && cell_free) begin
                            board[{cell_idx, 1'b0} +: 2] <= code;
                            if (move_count != 4'd9)
                                move_count <= move_count + 4'd1;
                            move_valid <= 1'b1;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (|win_hits) begin
                            game_state <= player ? 2'b10 : 2'b01;
                            win_line   <= win_hits;
                            state      <= OVER;
                        end else if (move_count == 4'd9) begin
                            game_state <= 2'b11;
                            state      <= OVER;
                        end else begin
                            player <= ~player;
                            state  <= PLAY;
                        end
                    end
                    OVER: state <= OVER;
                    default: state <= PLAY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with a short debounce window.
module tb_ttt_game_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [8:0]  btn_n;
    logic        new_game_n;
    logic [17:0] board;
    logic        player;
    logic [1:0]  game_state;
    logic [7:0]  win_line;
    logic [3:0]  move_count;
    logic        move_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int mv_cnt   = 0;
    int k;
    int mv0;

    always #5 CLK = ~CLK;

    ttt_game_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_n      (btn_n),
        .new_game_n (new_game_n),
        .board      (board),
        .player     (player),
        .game_state (game_state),
        .win_line   (win_line),
        .move_count (move_count),
        .move_valid (move_valid)
    );

    always @(negedge CLK) if (move_valid) mv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tap(input int idx);
        btn_n[idx] = 1'b0;
        repeat (10) @(negedge CLK);
        btn_n[idx] = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic new_game();
        new_game_n = 1'b0;
        repeat (10) @(negedge CLK);
        new_game_n = 1'b1;
        repeat (10) @(negedge CLK);
    endtask

    task automatic play_seq(input int s[9], input int n);
        for (int i = 0; i < n; i++) tap(s[i]);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_board"}, 32'(board), 32'h0);
        check({tag, "_player"}, 32'(player), 32'h0);
        check({tag, "_state"}, 32'(game_state), 32'h0);
        check({tag, "_line"}, 32'(win_line), 32'h0);
        check({tag, "_count"}, 32'(move_count), 32'h0);
        check({tag, "_mv"}, 32'(move_valid), 32'h0);
    endtask

    initial begin
        RST        = 1'b0;
        btn_n      = '1;
        new_game_n = 1'b1;
        repeat (3) @(negedge CLK);
        check_idle("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Three-cycle glitch must not get through the debouncer
        btn_n[4] = 1'b0;
        repeat (3) @(negedge CLK);
        btn_n[4] = 1'b1;
        repeat (10) @(negedge CLK);
        check("glitch_mv", 32'(mv_cnt), 32'd0);
        check("glitch_board", 32'(board), 32'h0);

        // Held press: 2 sync + 4 debounce + 1 write stage
        btn_n[4] = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!move_valid && k < 20);
        check("latency", 32'(k), 32'd7);
        check("hold_cell4", 32'(board[9:8]), 32'h1);
        check("hold_player_n1", 32'(player), 32'h0);
        @(negedge CLK);
        check("hold_player_n2", 32'(player), 32'h1);
        check("hold_count", 32'(move_count), 32'd1);
        btn_n[4] = 1'b1;
        repeat (10) @(negedge CLK);
        check("hold_mv", 32'(mv_cnt), 32'd1);

        // New game mid-game
        new_game();
        check_idle("newgame");
        tap(0);
        check("ng_cell0", 32'(board), 32'h1);

        // Simultaneous cells 2 and 7
        new_game();
        mv0 = mv_cnt;
        btn_n[2] = 1'b0;
        btn_n[7] = 1'b0;
        repeat (10) @(negedge CLK);
        btn_n[2] = 1'b1;
        btn_n[7] = 1'b1;
        repeat (10) @(negedge CLK);
        check("simul_board", 32'(board), 32'h10);
        check("simul_mv", 32'(mv_cnt - mv0), 32'd1);
        tap(7);
        check("simul_cell7", 32'(board), 32'h8010);

        // Diagonal win for X
        new_game();
        play_seq('{0, 1, 4, 2, 8, 0, 0, 0, 0}, 5);
        check("diag_state", 32'(game_state), 32'h1);
        check("diag_line", 32'(win_line), 32'h40);
        check("diag_player", 32'(player), 32'h0);
        check("diag_count", 32'(move_count), 32'd5);
        mv0 = mv_cnt;
        tap(3);
        check("over_mv", 32'(mv_cnt - mv0), 32'd0);
        check("over_board", 32'(board), 32'h10129);

        // Draw
        new_game();
        play_seq('{0, 1, 2, 4, 3, 5, 7, 6, 8}, 9);
        check("draw_state", 32'(game_state), 32'h3);
        check("draw_count", 32'(move_count), 32'd9);
        check("draw_line", 32'(win_line), 32'h0);

        // Ninth move completes row 0 and col 0 together
        new_game();
        play_seq('{3, 4, 6, 5, 1, 7, 2, 8, 0}, 9);
        check("dbl_state", 32'(game_state), 32'h1);
        check("dbl_line", 32'(win_line), 32'h09);
        check("dbl_count", 32'(move_count), 32'd9);

        // Asynchronous reset while in CHECK
        new_game();
        btn_n[4] = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!move_valid && k < 20);
        check("rst_reach_check", 32'(move_valid), 32'h1);
        RST   = 1'b0;
        btn_n = '1;
        #1;
        check_idle("rst_check");
        @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        tap(0);
        check("rst_cell0", 32'(board), 32'h1);
        check("rst_player", 32'(player), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Game controller for the 3x3 tic-tac-toe display. Turns raw active-low cell buttons into legal moves, alternates players, detects win/draw, and drives the board state read by the display renderer. Owns all board registers; the display block becomes a pure reader of board/game_state/win_line.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronized samples required to accept a button level change
CNT_W, 16, width of each debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
btn_n  in  9  raw cell buttons, active-low; index i = 3*row + col
new_game_n  in  1  raw new-game button, active-low
board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 player 0 (X), 10 player 1 (O); 11 never driven
player  out  1  side to move (0 = X)
game_state  out  2  00 playing, 01 X won, 10 O won, 11 draw
win_line  out  8  one-hot winning lines: bits 0-2 rows 0-2, 3-5 cols 0-2, 6 diag 0-4-8, 7 anti-diag 2-4-6
move_count  out  4  occupied cells, 0..9
move_valid  out  1  one-cycle pulse when a move is written to board

Behaviour:
- Reset (RST low, async): board=0, player=0, game_state=00, win_line=0, move_count=0, move_valid=0, FSM=PLAY, synchronizers and debounce state cleared to "released".
- Input conditioning: each of the 10 buttons passes a 2-FF synchronizer, then a debouncer: debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from the current level; any mismatch restarts the count.
- Press event: debounced level released->pressed transition, one cycle wide. Holding a button produces exactly one event.
- Arbitration: multiple cell events in the same cycle -> lowest index wins; others discarded, not queued.
- FSM states: PLAY, CHECK, OVER.
- PLAY: event on cell i with board cell i == 00 -> next cycle: cell i written to {player, ~player} (01 for X, 10 for O), move_count+1, move_valid=1 for that cycle, FSM->CHECK. Event on an occupied cell: ignored, no state change.
- CHECK (one cycle): evaluate all 8 lines on the updated board. A line wins when all three cells equal the mover's code. Any win -> game_state = 01 (X) or 10 (O), win_line = all winning lines (two simultaneous lines both set), FSM->OVER, player unchanged. Else move_count==9 -> game_state=11, FSM->OVER. Else player toggles, FSM->PLAY.
- Latency: debounced event in cycle N -> board/move_valid in N+1 -> game_state/win_line/player in N+2. Next move accepted from N+2.
- Cell events during CHECK or OVER are discarded.
- New game: debounced new_game_n press event (any state, including CHECK) -> next cycle same values as reset except debounce/synchronizer state kept. It takes priority over a cell event in the same cycle. Buttons held across a new game do not re-fire until released and pressed again.
- A win on move 9 reports win (01/10), not draw.
- move_count saturates at 9; it is never incremented in OVER.

Test Plan:
- DEBOUNCE_CYCLES=4. Pulse btn_n[4] low 3 cycles then high -> no move_valid, board=0. Hold low 10 cycles -> exactly one move_valid, board[9:8]=01, player=1 two cycles after the pulse.
- Simultaneous press of cells 2 and 7 in PLAY -> only cell 2 written (board[5:4]=01). Cell 7 stays 00 until it is released and pressed again.
- X at 0,4,8 with O at 1,2 interleaved -> after X's third move game_state=01, win_line=8'h40, player=0. A further press on cell 3 is ignored.
- Move order X0 O1 X2 O4 X3 O5 X7 O6 X8 -> game_state=11, move_count=9, win_line=0.
- X fills 0,1,2,3,6 with O on 4,5,7,8 so the final move completes row 0 and col 0 -> win_line=8'h09, game_state=01.
- Press new_game mid-game; assert RST during CHECK -> in both cases all outputs return to the reset values and a following press on cell 0 writes 01.
